// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between the AHB-to-APB bridge (master) and a completer (slave).
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 completer: ID register, transfer/error statistics register and a bank of
// R/W words, with a programmable number of wait states per access.
module apb_slave_regfile #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
  input  logic                hclk,
  input  logic                hreset,
  apb_slave_regfile_if.slave  apb
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] NUM_IDX   = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_ID    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STAT  = IDX_W'(1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [15:0]        xfer_cnt_q;
  logic [15:0]        err_cnt_q;

  logic [IDX_W-1:0]   bus_idx;
  logic [1:0]         unused_paddr_lsb;
  logic               rsp_write;
  logic [IDX_W-1:0]   rsp_idx;
  logic               rsp_err;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               commit;
  logic               reg_wr_en;
  logic               stat_clr;

  assign bus_idx          = apb.paddr[ADDR_W-1:2];
  assign unused_paddr_lsb = apb.paddr[1:0];

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

  // Response decode; with zero wait states the setup-phase bus values are used directly.
  always_comb begin
    rsp_write = (state_q == S_IDLE) ? apb.pwrite : wr_q;
    rsp_idx   = (state_q == S_IDLE) ? bus_idx    : idx_q;
    rsp_err   = (rsp_idx >= NUM_IDX) || (rsp_write && (rsp_idx == IDX_ID));
    rsp_rdata = '0;
    if (!rsp_write && !rsp_err) begin
      if (rsp_idx == IDX_ID) begin
        rsp_rdata = DATA_W'(ID_VALUE);
      end else if (rsp_idx == IDX_STAT) begin
        rsp_rdata = DATA_W'({err_cnt_q, xfer_cnt_q});
      end else begin
        rsp_rdata = regs[rsp_idx[SEL_W-1:0]];
      end
    end
  end

  // Next-state and registered-output logic; pready is set one edge ahead so it is high in the final access cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (apb.psel && !apb.penable) begin
          wr_d    = apb.pwrite;
          idx_d   = bus_idx;
          wdata_d = apb.pwdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == '0) begin
            state_d   = S_DONE;
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_rdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!apb.psel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (apb.penable) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d   = S_DONE;
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_rdata;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched transfer and output registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign commit    = (state_q == S_DONE);
  assign stat_clr  = commit && wr_q && (idx_q == IDX_STAT);
  assign reg_wr_en = commit && wr_q && !pslverr_q && (idx_q > IDX_STAT);

  // Register bank; writes commit at the end of the pready cycle.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (reg_wr_en) begin
      regs[idx_q[SEL_W-1:0]] <= wdata_q;
    end
  end

  // Statistics: each half counts and wraps on its own; a STAT write clears and is not counted.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (stat_clr) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (commit) begin
      xfer_cnt_q <= xfer_cnt_q + 16'(1);
      err_cnt_q  <= err_cnt_q + 16'(pslverr_q);
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: two completers (2 wait states and 0 wait states) share one
// APB driver through a select mux; a behavioural model predicts every response.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA2B0_0001;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset;
  logic        sel;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;

  always #5 clk = ~clk;

  apb_slave_regfile_if #(.ADDR_W(12), .DATA_W(32)) bus2 ();
  apb_slave_regfile_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();

  assign bus2.psel    = psel & ~sel;
  assign bus2.penable = penable;
  assign bus2.pwrite  = pwrite;
  assign bus2.paddr   = paddr;
  assign bus2.pwdata  = pwdata;
  assign bus0.psel    = psel & sel;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;

  apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut2 (.hclk(clk), .hreset(hreset), .apb(bus2));
  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (.hclk(clk), .hreset(hreset), .apb(bus0));

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;
  assign pready_m  = sel ? bus0.pready  : bus2.pready;
  assign pslverr_m = sel ? bus0.pslverr : bus2.pslverr;
  assign prdata_m  = sel ? bus0.prdata  : bus2.prdata;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  // Reference model state, one copy per completer (index 0: 2 waits, 1: 0 waits).
  logic [31:0] m_regs [2][16];
  int          m_xfer [2];
  int          m_err  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_regs[d][i] = 32'h0;
      m_xfer[d] = 0;
      m_err[d]  = 0;
    end
  endfunction

  // Predicted response of one completed transfer, then the model's state update.
  function automatic exp_t model_xfer(input int d, input logic wr, input logic [11:0] a,
                                      input logic [31:0] wd);
    exp_t e;
    int   idx;
    idx     = int'(a >> 2);
    e.err   = (idx >= 16) || (wr && idx == 0);
    e.rdata = 32'h0;
    e.waits = (d == 1) ? 0 : 2;
    if (!wr && !e.err) begin
      if (idx == 0)      e.rdata = ID;
      else if (idx == 1) e.rdata = (32'(m_err[d]) << 16) | 32'(m_xfer[d]);
      else               e.rdata = m_regs[d][idx];
    end
    if (wr && idx == 1) begin
      m_xfer[d] = 0;
      m_err[d]  = 0;
    end else begin
      if (wr && !e.err) m_regs[d][idx] = wd;
      m_xfer[d] = (m_xfer[d] + 1) % 65536;
      if (e.err) m_err[d] = (m_err[d] + 1) % 65536;
    end
    return e;
  endfunction

  // Monitor: pops an expectation whenever the selected completer raises pready.
  int wait_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (hreset) begin
      wait_cnt = 0;
    end else if (pready_m) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready=1 expected no transfer at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("prdata",  prdata_m,       e.rdata);
        check("pslverr", 32'(pslverr_m), 32'(e.err));
        check("waits",   32'(wait_cnt),  32'(e.waits));
      end
      wait_cnt = 0;
    end else begin
      if (psel) begin
        check("idle_prdata",  prdata_m,       32'h0);
        check("idle_pslverr", 32'(pslverr_m), 32'h0);
      end
      if (psel && penable) wait_cnt++;
      else if (!psel)      wait_cnt = 0;
    end
  end

  // One APB transfer; abort_after >= 0 drops psel after that many access cycles.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      input int abort_after);
    int n;
    sel     = (d == 1);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    if (abort_after < 0) exp_q.push_back(model_xfer(d, wr, a, wd));
    @(posedge clk); #1;
    penable = 1'b1;
    if (abort_after >= 0) begin
      repeat (abort_after) @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(posedge clk); #1;
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready_m && n < 40);
    if (!pready_m) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout: got no pready expected one within 40 cycles at %0t", $time);
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hreset = 1'b0;
    model_clear();
  endtask

  initial begin
    sel     = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    do_reset();

    @(negedge clk);
    check("rst_pready2",  32'(bus2.pready),  32'h0);
    check("rst_pslverr2", 32'(bus2.pslverr), 32'h0);
    check("rst_prdata2",  bus2.prdata,       32'h0);
    check("rst_pready0",  32'(bus0.pready),  32'h0);
    @(posedge clk); #1;

    // ID read, write/read-back and statistics on the 2-wait completer.
    xfer(0, 1'b0, 12'h000, 32'h0, -1);
    xfer(0, 1'b1, 12'h008, 32'hDEAD_BEEF, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);
    xfer(0, 1'b0, 12'h008, 32'h0, -1);
    // Out-of-range read and ID write both error.
    xfer(0, 1'b0, 12'h040, 32'h0, -1);
    xfer(0, 1'b1, 12'h000, 32'h1234_5678, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);
    xfer(0, 1'b0, 12'h000, 32'h0, -1);
    // Aborted write leaves the register and counts untouched.
    xfer(0, 1'b1, 12'h00C, 32'h0000_0055, 1);
    xfer(0, 1'b0, 12'h00C, 32'h0, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);
    // Zero-wait completer, back-to-back writes with setup right after pready.
    xfer(1, 1'b1, 12'h010, 32'hCAFE_0010, -1);
    xfer(1, 1'b1, 12'h014, 32'hCAFE_0014, -1);
    xfer(1, 1'b0, 12'h010, 32'h0, -1);
    xfer(1, 1'b0, 12'h017, 32'h0, -1);
    xfer(1, 1'b0, 12'h004, 32'h0, -1);

    // Access phase with no setup must be ignored.
    sel     = 1'b0;
    psel    = 1'b1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;

    // Reset during the wait phase of a write.
    sel     = 1'b0;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h018;
    pwdata  = 32'h1111_2222;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_mid_pready", 32'(bus2.pready), 32'h0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 12'h018, 32'h0, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);

    // STAT write clears the counts after a few transfers.
    xfer(0, 1'b1, 12'h020, 32'h0000_00A5, -1);
    xfer(0, 1'b1, 12'h004, 32'h0, -1);
    xfer(0, 1'b0, 12'h004, 32'h0, -1);

    // Randomized mix across both completers.
    for (int k = 0; k < 120; k++) begin
      int          d;
      int          ab;
      logic        wr;
      logic [11:0] a;
      d  = int'($urandom % 2);
      wr = 1'($urandom % 2);
      a  = 12'((($urandom % 20) << 2) | ($urandom % 4));
      ab = -1;
      if (d == 0 && ($urandom % 8) == 0) ab = int'($urandom % 2);
      xfer(d, wr, a, $urandom, ab);
      if (($urandom % 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    xfer(0, 1'b0, 12'h004, 32'h0, -1);
    xfer(1, 1'b0, 12'h004, 32'h0, -1);

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
